raster_zpipe: RTL and testbench

Parametrised successor to the single-triangle rasterizer. Walks a triangle's bounding box with incremental edge equations and interpolates screen-space depth. Does a configurable-latency z-buffer read/compare/write and emits frame-buffer writes. Sits between the MicroBlaze triangle-setup registers and the frame-buffer/z-buffer BRAM ports. Adds a bounding-box clear mode, depth-test/write enables, a write-stall input, degenerate-box handling and a pixel-write counter.

---
 rtl/raster_pkg.sv | 48 ++++
 rtl/raster_zinterp.sv | 77 +++++++
 rtl/raster_zpipe.sv | 233 +++++++++++++++++++++++
 tb/tb_raster_zpipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
`default_nettype none
// raster_pkg: shared state encoding and width/saturation helpers for the z-pipelined rasterizer.
package raster_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP_MUL,
        S_SETUP_SUM,
        S_ROW,
        S_TEST,
        S_ZMUL1,
        S_ZMUL2,
        S_ZADDR,
        S_ZREAD,
        S_WRITE,
        S_STEP,
        S_NEXTROW,
        S_DONE
    } state_t;

    localparam int SAT_W = 96;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int addr_width(input int w, input int h);
        return $clog2(w * h);
    endfunction

    // Edge accumulators must also hold the widest c constant without truncation.
    function automatic int edge_width(input int coef_w, input int x_w, input int y_w, input int c_w);
        return max_int(coef_w + max_int(x_w, y_w) + 3, c_w + 1);
    endfunction

    function automatic logic [31:0] sat_shift(input logic signed [SAT_W-1:0] p,
                                              input int frac, input int zw);
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] zmax;
        sh   = p >>> frac;
        zmax = (SAT_W'(1) <<< zw) - SAT_W'(1);
        if (sh[SAT_W-1]) return '0;
        if (sh > zmax)   return zmax[31:0];
        return sh[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_zinterp.sv
`default_nettype none
// raster_zinterp: two-stage registered depth interpolation, z = sat((sum e_i*z_i * inv_area) >>> INV_FRAC).
module raster_zinterp
    import raster_pkg::*;
#(
    parameter int EW       = 22,
    parameter int Z_W      = 8,
    parameter int INV_FRAC = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vin_i,
    input  logic                  clear_i,
    input  logic signed [EW-1:0]  e1_i,
    input  logic signed [EW-1:0]  e2_i,
    input  logic signed [EW-1:0]  e3_i,
    input  logic [Z_W-1:0]        z1_i,
    input  logic [Z_W-1:0]        z2_i,
    input  logic [Z_W-1:0]        z3_i,
    input  logic [31:0]           inv_area_i,
    output logic [Z_W-1:0]        z_o,
    output logic                  vout_o
);

    localparam int SW = EW + Z_W + 3;
    localparam int PW = SW + 33;

    logic signed [SW-1:0] e_x [3];
    logic signed [SW-1:0] z_x [3];
    logic signed [SW-1:0] s_d;
    logic signed [SW-1:0] s_q;
    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] inv_ext;
    logic signed [PW-1:0] p_d;
    logic [31:0]          sat_d;
    logic                 v1_q;
    logic                 vld_q;
    logic [Z_W-1:0]       z_q;

    always_comb begin
        e_x[0]  = SW'(e1_i);
        e_x[1]  = SW'(e2_i);
        e_x[2]  = SW'(e3_i);
        z_x[0]  = SW'(z1_i);
        z_x[1]  = SW'(z2_i);
        z_x[2]  = SW'(z3_i);
        s_d     = e_x[0] * z_x[0] + e_x[1] * z_x[1] + e_x[2] * z_x[2];
        s_ext   = PW'(s_q);
        inv_ext = PW'(inv_area_i);
        p_d     = s_ext * inv_ext;
        sat_d   = sat_shift(SAT_W'(p_d), INV_FRAC, Z_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            v1_q  <= 1'b0;
            vld_q <= 1'b0;
            z_q   <= '0;
        end else begin
            v1_q <= vin_i;
            if (vin_i) begin
                s_q   <= s_d;
                vld_q <= 1'b0;
            end
            if (v1_q) begin
                z_q   <= clear_i ? '1 : Z_W'(sat_d);
                vld_q <= 1'b1;
            end
        end
    end

    assign z_o    = z_q;
    assign vout_o = vld_q;

endmodule
`default_nettype wire

// File: rtl/raster_zpipe.sv
`default_nettype none
// raster_zpipe: bounding-box triangle walker with incremental edges, depth interpolation and z-buffer test.
module raster_zpipe
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COLOR_W  = 8,
    parameter int Z_W      = 8,
    parameter int COEF_W   = 10,
    parameter int C_W      = 18,
    parameter int INV_FRAC = 24,
    parameter int ZBUF_LAT = 1,
    localparam int X_W     = $clog2(SCREEN_W),
    localparam int Y_W     = $clog2(SCREEN_H),
    localparam int ADDR_W  = addr_width(SCREEN_W, SCREEN_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_clear,
    input  logic               depth_test_en,
    input  logic               depth_write_en,
    input  logic [31:0]        inv_area,
    input  logic [COLOR_W-1:0] color,
    input  logic [COEF_W-1:0]  a1,
    input  logic [COEF_W-1:0]  b1,
    input  logic [COEF_W-1:0]  a2,
    input  logic [COEF_W-1:0]  b2,
    input  logic [COEF_W-1:0]  a3,
    input  logic [COEF_W-1:0]  b3,
    input  logic [C_W-1:0]     c1,
    input  logic [C_W-1:0]     c2,
    input  logic [C_W-1:0]     c3,
    input  logic [X_W-1:0]     bbxi,
    input  logic [X_W-1:0]     bbxf,
    input  logic [Y_W-1:0]     bbyi,
    input  logic [Y_W-1:0]     bbyf,
    input  logic [Z_W-1:0]     z1,
    input  logic [Z_W-1:0]     z2,
    input  logic [Z_W-1:0]     z3,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    pix_count,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_din,
    input  logic               fb_stall,
    output logic               zb_en,
    output logic               zb_we,
    output logic [ADDR_W-1:0]  zb_addr,
    output logic [Z_W-1:0]     zb_din,
    input  logic [Z_W-1:0]     zb_dout
);

    localparam int EW    = edge_width(COEF_W, X_W, Y_W, C_W);
    localparam int CNT_W = $clog2(ZBUF_LAT + 1) + 1;

    state_t               state_q;
    logic                 clear_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [CNT_W-1:0]     cnt_q;
    logic signed [EW-1:0] pa_q [3];
    logic signed [EW-1:0] pb_q [3];
    logic signed [EW-1:0] e_q  [3];
    logic signed [EW-1:0] er_q [3];

    logic signed [EW-1:0] a_s [3];
    logic signed [EW-1:0] b_s [3];
    logic signed [EW-1:0] c_s [3];
    logic signed [EW-1:0] xs_d;
    logic signed [EW-1:0] ys_d;
    logic                 inside_d;
    logic                 pass_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [Z_W-1:0]       zi_z;
    logic                 zi_vld;

    always_comb begin
        a_s[0]   = EW'($signed(a1));
        a_s[1]   = EW'($signed(a2));
        a_s[2]   = EW'($signed(a3));
        b_s[0]   = EW'($signed(b1));
        b_s[1]   = EW'($signed(b2));
        b_s[2]   = EW'($signed(b3));
        c_s[0]   = EW'($signed(c1));
        c_s[1]   = EW'($signed(c2));
        c_s[2]   = EW'($signed(c3));
        xs_d     = EW'(bbxi);
        ys_d     = EW'(bbyi);
        inside_d = clear_q || (!er_q[0][EW-1] && !er_q[1][EW-1] && !er_q[2][EW-1]);
        pass_d   = !depth_test_en || clear_q || (zi_z < zb_dout);
        addr_d   = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(x_q);
    end

    raster_zinterp #(
        .EW       (EW),
        .Z_W      (Z_W),
        .INV_FRAC (INV_FRAC)
    ) u_zinterp (
        .clk        (clk),
        .rst        (rst),
        .vin_i      (state_q == S_ZMUL1),
        .clear_i    (clear_q),
        .e1_i       (er_q[0]),
        .e2_i       (er_q[1]),
        .e3_i       (er_q[2]),
        .z1_i       (z1),
        .z2_i       (z2),
        .z3_i       (z3),
        .inv_area_i (inv_area),
        .z_o        (zi_z),
        .vout_o     (zi_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clear_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_din    <= '0;
            zb_en     <= 1'b0;
            zb_we     <= 1'b0;
            zb_addr   <= '0;
            zb_din    <= '0;
            for (int i = 0; i < 3; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
                e_q[i]  <= '0;
                er_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        clear_q   <= mode_clear;
                        busy      <= 1'b1;
                        pix_count <= '0;
                        y_q       <= bbyi;
                        state_q   <= (bbxi > bbxf || bbyi > bbyf) ? S_DONE : S_SETUP_MUL;
                    end
                end
                S_SETUP_MUL: begin
                    for (int i = 0; i < 3; i++) begin
                        pa_q[i] <= a_s[i] * xs_d;
                        pb_q[i] <= b_s[i] * ys_d;
                    end
                    state_q <= S_SETUP_SUM;
                end
                S_SETUP_SUM: begin
                    for (int i = 0; i < 3; i++) e_q[i] <= pa_q[i] + pb_q[i] + c_s[i];
                    state_q <= S_ROW;
                end
                S_ROW: begin
                    x_q <= bbxi;
                    for (int i = 0; i < 3; i++) er_q[i] <= e_q[i];
                    state_q <= S_TEST;
                end
                S_TEST:  state_q <= inside_d ? S_ZMUL1 : S_STEP;
                S_ZMUL1: state_q <= S_ZMUL2;
                S_ZMUL2: state_q <= S_ZADDR;
                S_ZADDR: begin
                    fb_addr <= addr_d;
                    zb_addr <= addr_d;
                    zb_en   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_ZREAD;
                end
                // The final count cycle is where read data is valid; the write decision is registered here.
                S_ZREAD: begin
                    if (cnt_q == CNT_W'(ZBUF_LAT) && zi_vld) begin
                        if (pass_d) begin
                            fb_we     <= 1'b1;
                            fb_din    <= color;
                            zb_we     <= depth_write_en || clear_q;
                            zb_din    <= zi_z;
                            pix_count <= pix_count + (ADDR_W+1)'(1);
                        end
                        state_q <= S_WRITE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!(fb_we && fb_stall)) begin
                        fb_we   <= 1'b0;
                        zb_we   <= 1'b0;
                        zb_en   <= 1'b0;
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    fb_we <= 1'b0;
                    zb_we <= 1'b0;
                    zb_en <= 1'b0;
                    if (x_q == bbxf) begin
                        state_q <= S_NEXTROW;
                    end else begin
                        x_q <= x_q + X_W'(1);
                        for (int i = 0; i < 3; i++) er_q[i] <= er_q[i] + a_s[i];
                        state_q <= S_TEST;
                    end
                end
                S_NEXTROW: begin
                    if (y_q == bbyf) begin
                        state_q <= S_DONE;
                    end else begin
                        y_q <= y_q + Y_W'(1);
                        for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] + b_s[i];
                        state_q <= S_ROW;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_raster_zpipe.sv
`default_nettype none
// tb_raster_zpipe: directed and random jobs checked against a pixel-loop reference model.
module tb_raster_zpipe;

    localparam int SW = 16, SH = 8, LAT = 1, ZW = 8, CW = 8, COEFW = 10, CCW = 18, FRAC = 24;
    localparam int XW = 4, YW = 3, AW = 7, NPIX = SW * SH;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic mode_clear = 1'b0, depth_test_en = 1'b1, depth_write_en = 1'b1, fb_stall = 1'b0;
    logic [31:0] inv_area = '0;
    logic [CW-1:0] color = '0;
    logic [COEFW-1:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0, a3 = '0, b3 = '0;
    logic [CCW-1:0] c1 = '0, c2 = '0, c3 = '0;
    logic [XW-1:0] bbxi = '0, bbxf = '0;
    logic [YW-1:0] bbyi = '0, bbyf = '0;
    logic [ZW-1:0] z1 = '0, z2 = '0, z3 = '0;
    logic busy, done, fb_we, zb_en, zb_we;
    logic [AW:0] pix_count;
    logic [AW-1:0] fb_addr, zb_addr;
    logic [CW-1:0] fb_din;
    logic [ZW-1:0] zb_din, zb_dout;

    raster_zpipe #(.SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(CW), .Z_W(ZW), .COEF_W(COEFW),
                   .C_W(CCW), .INV_FRAC(FRAC), .ZBUF_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_clear(mode_clear),
        .depth_test_en(depth_test_en), .depth_write_en(depth_write_en),
        .inv_area(inv_area), .color(color),
        .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
        .c1(c1), .c2(c2), .c3(c3),
        .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
        .z1(z1), .z2(z2), .z3(z3),
        .busy(busy), .done(done), .pix_count(pix_count),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .fb_stall(fb_stall),
        .zb_en(zb_en), .zb_we(zb_we), .zb_addr(zb_addr), .zb_din(zb_din), .zb_dout(zb_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] col;
        logic          zwe;
        logic [ZW-1:0] z;
    } wr_t;

    // Z-buffer BRAM (read-first, one-cycle latency) and frame-buffer write capture.
    logic [ZW-1:0] zmem [NPIX];
    logic          zfill = 1'b0;
    logic [ZW-1:0] zfill_val = '0;
    wr_t           dut_q [$];
    int            done_cnt = 0;

    always @(posedge clk) begin
        if (zfill) begin
            for (int i = 0; i < NPIX; i++) zmem[i] <= zfill_val;
        end else if (zb_en) begin
            if (zb_we) zmem[zb_addr] <= zb_din;
            zb_dout <= zmem[zb_addr];
        end
        if (!rst && fb_we && !fb_stall) dut_q.push_back('{fb_addr, fb_din, zb_we, zb_din});
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks = 0, failures = 0;
    int ja [3], jb [3], jc [3], jz [3];
    int jx0, jx1, jy0, jy1, jcol;
    longint jinv;
    bit jclear, jdt, jdw;
    logic [ZW-1:0] ref_z [NPIX];
    wr_t exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_job();
        logic [31:0] t;
        t = ja[0]; a1 = t[COEFW-1:0]; t = ja[1]; a2 = t[COEFW-1:0]; t = ja[2]; a3 = t[COEFW-1:0];
        t = jb[0]; b1 = t[COEFW-1:0]; t = jb[1]; b2 = t[COEFW-1:0]; t = jb[2]; b3 = t[COEFW-1:0];
        t = jc[0]; c1 = t[CCW-1:0];   t = jc[1]; c2 = t[CCW-1:0];   t = jc[2]; c3 = t[CCW-1:0];
        z1 = jz[0][ZW-1:0]; z2 = jz[1][ZW-1:0]; z3 = jz[2][ZW-1:0];
        bbxi = jx0[XW-1:0]; bbxf = jx1[XW-1:0]; bbyi = jy0[YW-1:0]; bbyf = jy1[YW-1:0];
        inv_area = jinv[31:0]; color = jcol[CW-1:0];
        mode_clear = jclear; depth_test_en = jdt; depth_write_en = jdw;
    endtask

    // Reference: visit every box pixel, evaluate edges and depth directly.
    task automatic model_job();
        longint e [3];
        longint s, p, z;
        int addr;
        exp_q.delete();
        if (jx0 > jx1 || jy0 > jy1) return;
        for (int y = jy0; y <= jy1; y++) begin
            for (int x = jx0; x <= jx1; x++) begin
                for (int i = 0; i < 3; i++) e[i] = longint'(ja[i]) * x + longint'(jb[i]) * y + jc[i];
                if (!jclear && (e[0] < 0 || e[1] < 0 || e[2] < 0)) continue;
                if (jclear) z = 255;
                else begin
                    s = e[0] * jz[0] + e[1] * jz[1] + e[2] * jz[2];
                    p = s * jinv;
                    z = p >>> FRAC;
                    if (z < 0) z = 0;
                    if (z > 255) z = 255;
                end
                addr = y * SW + x;
                if (!jdt || jclear || z < longint'(ref_z[addr])) begin
                    exp_q.push_back('{addr[AW-1:0], jcol[CW-1:0], jdw || jclear, z[ZW-1:0]});
                    if (jdw || jclear) ref_z[addr] = z[ZW-1:0];
                end
            end
        end
    endtask

    task automatic fill(input logic [ZW-1:0] v);
        zfill_val = v; zfill = 1'b1;
        @(negedge clk); zfill = 1'b0;
        for (int i = 0; i < NPIX; i++) ref_z[i] = v;
    endtask

    task automatic job1();
        ja = '{1, 0, -1}; jb = '{0, 1, -1}; jc = '{0, 0, 6}; jz = '{100, 100, 100};
        jx0 = 0; jx1 = 6; jy0 = 0; jy1 = 6; jinv = 2796203; jcol = 8'hA5;
        jclear = 0; jdt = 1; jdw = 1;
    endtask

    task automatic run_job(input string tag, input bit stall_first);
        int base, dbase, cyc, n;
        bit seen;
        logic [AW-1:0] a0;
        drive_job();
        model_job();
        base = dut_q.size(); dbase = done_cnt; cyc = 0; seen = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (done_cnt == dbase && cyc < 20000) begin
            if (stall_first && !seen && fb_we) begin
                seen = 1; fb_stall = 1'b1; a0 = fb_addr;
                repeat (3) begin
                    @(negedge clk);
                    check({tag, "_stall_we"}, fb_we, 1);
                    check({tag, "_stall_addr"}, fb_addr, a0);
                end
                fb_stall = 1'b0;
                @(negedge clk);
                check({tag, "_stall_drop"}, fb_we, 0);
            end
            @(negedge clk); cyc++;
        end
        check({tag, "_timeout"}, cyc < 20000, 1);
        @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - dbase, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_nwrites"}, dut_q.size() - base, exp_q.size());
        check({tag, "_pix_count"}, pix_count, exp_q.size());
        n = (dut_q.size() - base < exp_q.size()) ? dut_q.size() - base : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, dut_q[base + i], exp_q[i]);
    endtask

    initial begin
        int base, cyc;
        int clr_addr [6];
        clr_addr = '{18, 19, 20, 34, 35, 36};

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_fb_we", fb_we, 0);
        check("rst_zb_en", zb_en, 0); check("rst_zb_we", zb_we, 0); check("rst_pix", pix_count, 0);
        check("rst_addr", fb_addr, 0);
        rst = 1'b0;

        // 1: reference triangle into a far-cleared z-buffer
        fill(8'hFF); job1();
        base = dut_q.size();
        run_job("job1", 0);
        check("job1_count", dut_q.size() - base, 28);
        if (dut_q.size() > base) check("job1_zdin", dut_q[base].z, 100);

        // 2: equal depth fails; depth test off always passes
        run_job("job1_equal", 0);
        jdt = 0;
        run_job("job1_notest", 0);

        // 3: clear mode
        job1(); jclear = 1; jcol = 8'h3C; jx0 = 2; jx1 = 4; jy0 = 1; jy1 = 2;
        base = dut_q.size();
        run_job("clear", 0);
        check("clear_count", dut_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (dut_q.size() > base + i) begin
                check("clear_addr", dut_q[base + i].addr, clr_addr[i]);
                check("clear_z", dut_q[base + i].z, 8'hFF);
                check("clear_col", dut_q[base + i].col, 8'h3C);
            end
        end

        // 4: degenerate box finishes two cycles after start
        job1(); jx0 = 5; jx1 = 4; drive_job(); model_job();
        base = dut_q.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("degen_busy", busy, 1); check("degen_done_early", done, 0);
        @(negedge clk);
        check("degen_done", done, 1); check("degen_busy_low", busy, 0);
        check("degen_pix", pix_count, 0);
        @(negedge clk);
        check("degen_done_pulse", done, 0);
        check("degen_writes", dut_q.size() - base, 0);

        // 5: stall on the first write
        fill(8'hFF); job1();
        base = dut_q.size();
        run_job("stall", 1);
        check("stall_count", dut_q.size() - base, 28);

        // 6: reset mid-job, then a clean rerun
        fill(8'hFF); job1(); drive_job();
        base = dut_q.size(); cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (dut_q.size() - base < 10 && cyc < 5000) begin @(negedge clk); cyc++; end
        check("midrst_reach10", cyc < 5000, 1);
        rst = 1'b1; #1;
        check("midrst_busy", busy, 0); check("midrst_fb_we", fb_we, 0); check("midrst_zb_we", zb_we, 0);
        check("midrst_zb_en", zb_en, 0); check("midrst_pix", pix_count, 0); check("midrst_fb_addr", fb_addr, 0);
        check("midrst_zb_addr", zb_addr, 0); check("midrst_fb_din", fb_din, 0); check("midrst_zb_din", zb_din, 0);
        @(negedge clk); rst = 1'b0;
        fill(8'hFF); job1();
        run_job("after_rst", 0);

        // Random jobs
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 2) == 0) fill(8'($urandom_range(0, 255)));
            for (int i = 0; i < 3; i++) begin
                ja[i] = int'($urandom_range(0, 16)) - 8;
                jb[i] = int'($urandom_range(0, 16)) - 8;
                jc[i] = int'($urandom_range(0, 120)) - 40;
                jz[i] = $urandom_range(0, 255);
            end
            jx0 = $urandom_range(0, SW - 1); jx1 = $urandom_range(jx0, SW - 1);
            jy0 = $urandom_range(0, SH - 1); jy1 = $urandom_range(jy0, SH - 1);
            jinv = $urandom_range(1 << 18, 1 << 25); jcol = $urandom_range(0, 255);
            jclear = ($urandom_range(0, 5) == 0); jdt = $urandom_range(0, 1); jdw = $urandom_range(0, 1);
            run_job($sformatf("rand%0d", t), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
